ov7670_stream_gen: RTL
======================

# ov7670_stream_gen

Synthesizable OV7670 pixel-bus source that emits vsync/href/8-bit data frames in RGB444 (xRGB) byte order, exactly as the camera drives them into the capture path. It stands in for the sensor on the far end of the camera interface. Uses:
- board bring-up without a camera attached;
- closed-loop simulation of capture → frame buffer → VGA;
- a known-pattern source for address/resolution debugging.

## Interface
Parameters:
- H_ACTIVE, 640, active pixels per line; must be a multiple of 8.
- V_ACTIVE, 480, active lines per frame.
- H_BLANK, 144, clocks per line with href low, following the active bytes.
- VSYNC_LINES, 3, line-times with vsync high.
- VBP_LINES, 17, blank line-times after vsync.
- VFP_LINES, 10, blank line-times after the last active line.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  pixel-byte clock; one output byte per cycle.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  start/continue frames.
- mode  in  2  pattern: 00 colour bars, 01 grey ramp, 10 checkerboard, 11 solid.
- solid_rgb  in  12  {R,G,B} nibbles used in mode 11.
- vsync  out  1  frame sync, high during VSYNC state.
- href  out  1  high while active bytes are valid.
- data  out  8  pixel byte.
- frame_done  out  1  one-cycle pulse on the last clock of each frame.
- frame_count  out  16  completed frames; wraps 0xFFFF → 0.

## Operation
- Line length L = 2*H_ACTIVE + H_BLANK clocks.
- Counters:
  - col: 0..L-1;
  - line: per-state line counter;
  - y: active row;
  - x = col>>1.
- FSM states: IDLE, VSYNC, VBP, ACTIVE, VFP.
  - IDLE → VSYNC when en=1.
  - VSYNC → VBP after VSYNC_LINES lines.
  - VBP → ACTIVE after VBP_LINES lines.
  - ACTIVE → VFP after V_ACTIVE lines.
  - VFP → VSYNC if en=1, else IDLE, after VFP_LINES lines.
- en is checked only in IDLE and at the end of VFP. Deasserting en mid-frame lets the frame complete.
- mode and solid_rgb are latched on entry to VSYNC. Changes mid-frame have no effect.
- href = 1 in ACTIVE when col < 2*H_ACTIVE.
- Byte order per pixel:
  - even col → data = {4'h0, R};
  - odd col → data = {G, B}.
- data = 8'h00 whenever href = 0.
- Patterns:
  - Bars: bar index increments every H_ACTIVE/8 pixels, no divider. Colours in order FFF, FF0, 0FF, 0F0, F0F, F00, 00F, 000.
  - Ramp: R=G=B=x[5:2].
  - Checker: (x[4]^y[4]) ? FFF : 000.
  - Solid: latched solid_rgb.
- frame_done = 1 on the last clock of VFP (col=L-1, final line). On that same edge frame_count increments.

## Timing
- All outputs are registered from next-state logic.
  - vsync rises on the same edge on which IDLE samples en=1.
  - href rises on the first edge of ACTIVE.
- Consumers sample on the following rising edge; outputs are stable for a full cycle.
- Frame period = (VSYNC_LINES + VBP_LINES + V_ACTIVE + VFP_LINES) * L clocks. Back-to-back frames have no gap.
- Reset values: state IDLE, all counters 0, and vsync=0, href=0, data=0, frame_done=0, frame_count=0.
- rst mid-frame aborts immediately to IDLE. No partial-frame frame_done.
- Width rules:
  - col width is clog2(L).
  - Line counter width is clog2(max(VSYNC_LINES, VBP_LINES, V_ACTIVE, VFP_LINES)).
  - y width is clog2(V_ACTIVE).
  - No arithmetic may overflow for any legal parameter set.

## Structure
- Package ov7670_gen_pkg:
  - state enum;
  - mode constants;
  - the eight bar colour constants.
- Sub-module ov7670_pattern_lut (combinational): inputs mode, x, y, bar_idx, solid → output rgb12. The top holds the FSM, the counters, the bar counter and the output registers.

## Test plan
Bench parameters: H_ACTIVE=16, V_ACTIVE=4, H_BLANK=4, VSYNC_LINES=1, VBP_LINES=1, VFP_LINES=1, so L=36 and the frame is 252 clocks.
- Reset then en=1, mode=11, solid_rgb=12'hA5C → vsync high for 36 clocks. First href rises 72 clocks after vsync rise. Bytes alternate 0A, 5C for 32 clocks per line, with 4 blank clocks at data=00.
- mode=00 → each line gives 2 pixels per bar: FFF,FFF,FF0,FF0,…,000. Bytes read 0F FF 0F FF 0F F0 …
- mode=10 → x 0–15 all one colour, y 0–3 all one colour: every active pixel is FFF if checker parity is 1, else 000. Check against y[4]^x[4]=0 → all 000.
- en held high for 3 frames → frame_done pulses at clocks 251, 503, 755 after start. frame_count ends at 3. No gap between frames.
- en dropped at clock 100 → frame completes, frame_done fires at 251, then IDLE with vsync=0. Mode changed at clock 120 → no effect on the current frame.
- rst asserted at clock 150 → all outputs 0 asynchronously. frame_count=0 and no frame_done. After release with en=1, a new frame starts cleanly.

Source files
------------

// File: rtl/ov7670_gen_pkg.sv
// Shared types and constants for the OV7670 stream generator.
// States, pattern modes and bar colours.
package ov7670_gen_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSYNC,
    ST_VBP,
    ST_ACTIVE,
    ST_VFP
  } state_e;

  localparam logic [1:0] MODE_BARS  = 2'b00;
  localparam logic [1:0] MODE_RAMP  = 2'b01;
  localparam logic [1:0] MODE_CHECK = 2'b10;
  localparam logic [1:0] MODE_SOLID = 2'b11;

  localparam logic [11:0] BAR_0 = 12'hFFF;
  localparam logic [11:0] BAR_1 = 12'hFF0;
  localparam logic [11:0] BAR_2 = 12'h0FF;
  localparam logic [11:0] BAR_3 = 12'h0F0;
  localparam logic [11:0] BAR_4 = 12'hF0F;
  localparam logic [11:0] BAR_5 = 12'hF00;
  localparam logic [11:0] BAR_6 = 12'h00F;
  localparam logic [11:0] BAR_7 = 12'h000;

  // Width of the coordinate buses handed to the pattern LUT
  localparam int XY_W = 16;

  // clog2 that never returns a zero width
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int max4(input int a, input int b,
                              input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/ov7670_pattern_lut.sv
// Combinational pattern generator: maps mode and pixel
// position to a 12-bit {R,G,B} colour.
module ov7670_pattern_lut
  import ov7670_gen_pkg::*;
(
  input  logic [1:0]  mode_i,
  input  logic [5:0]  x_i,
  input  logic [4:0]  y_i,
  input  logic [2:0]  bar_idx_i,
  input  logic [11:0] solid_i,
  output logic [11:0] rgb_o
);

  logic [11:0] bar_rgb;
  logic        unused_bits;

  // Low coordinate bits do not affect any pattern
  assign unused_bits = ^{y_i[3:0], x_i[1:0]};

  // Colour bar table
  always_comb begin
    bar_rgb = BAR_7;
    unique case (bar_idx_i)
      3'd0: bar_rgb = BAR_0;
      3'd1: bar_rgb = BAR_1;
      3'd2: bar_rgb = BAR_2;
      3'd3: bar_rgb = BAR_3;
      3'd4: bar_rgb = BAR_4;
      3'd5: bar_rgb = BAR_5;
      3'd6: bar_rgb = BAR_6;
      3'd7: bar_rgb = BAR_7;
    endcase
  end

  // Pattern select
  always_comb begin
    rgb_o = 12'h000;
    unique case (mode_i)
      MODE_BARS:  rgb_o = bar_rgb;
      MODE_RAMP:  rgb_o = {x_i[5:2], x_i[5:2], x_i[5:2]};
      MODE_CHECK: rgb_o = (x_i[4] ^ y_i[4]) ? 12'hFFF : 12'h000;
      MODE_SOLID: rgb_o = solid_i;
    endcase
  end

endmodule

// File: rtl/ov7670_stream_gen.sv
// OV7670 pixel-bus source: vsync/href/data frames in RGB444
// byte order. All outputs are registered from next-state values.
module ov7670_stream_gen
  import ov7670_gen_pkg::*;
#(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int H_BLANK     = 144,
  parameter int VSYNC_LINES = 3,
  parameter int VBP_LINES   = 17,
  parameter int VFP_LINES   = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [1:0]  mode,
  input  logic [11:0] solid_rgb,
  output logic        vsync,
  output logic        href,
  output logic [7:0]  data,
  output logic        frame_done,
  output logic [15:0] frame_count
);

  localparam int L   = 2 * H_ACTIVE + H_BLANK;
  localparam int CW  = clog2_min1(L);
  localparam int LW  = clog2_min1(max4(VSYNC_LINES, VBP_LINES,
                                       V_ACTIVE, VFP_LINES));
  localparam int YW  = clog2_min1(V_ACTIVE);
  localparam int BPP = H_ACTIVE / 8;
  localparam int BW  = clog2_min1(BPP);

  localparam logic [CW-1:0] COL_LAST = CW'(L - 1);
  localparam logic [CW:0]   ACT_COLS = (CW + 1)'(2 * H_ACTIVE);
  localparam logic [LW-1:0] VS_LAST  = LW'(VSYNC_LINES - 1);
  localparam logic [LW-1:0] BP_LAST  = LW'(VBP_LINES - 1);
  localparam logic [LW-1:0] AC_LAST  = LW'(V_ACTIVE - 1);
  localparam logic [LW-1:0] FP_LAST  = LW'(VFP_LINES - 1);
  localparam logic [BW-1:0] BAR_LAST = BW'(BPP - 1);

  state_e state_q, state_d;

  logic [CW-1:0] col_q, col_d;
  logic [LW-1:0] line_q, line_d;
  logic [YW-1:0] y_q, y_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [2:0]    bar_q, bar_d;
  logic [1:0]    mode_q, mode_d;
  logic [11:0]   solid_q, solid_d;

  logic          vsync_q, vsync_d;
  logic          href_q, href_d;
  logic [7:0]    data_q, data_d;
  logic          fd_q, fd_d;
  logic [15:0]   fc_q, fc_d;

  logic            eol;
  logic [XY_W-1:0] x_full;
  logic [XY_W-1:0] y_full;
  logic [11:0]     rgb;
  logic            unused_xy;

  assign eol = (col_q == COL_LAST);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state: en only matters in IDLE and at the end of VFP
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:
        if (en) state_d = ST_VSYNC;
      ST_VSYNC:
        if (eol && line_q == VS_LAST) state_d = ST_VBP;
      ST_VBP:
        if (eol && line_q == BP_LAST) state_d = ST_ACTIVE;
      ST_ACTIVE:
        if (eol && line_q == AC_LAST) state_d = ST_VFP;
      ST_VFP:
        if (eol && line_q == FP_LAST)
          state_d = en ? ST_VSYNC : ST_IDLE;
      default:
        state_d = ST_IDLE;
    endcase
  end

  // Counter next values and mode latch on VSYNC entry
  always_comb begin
    col_d = (state_q == ST_IDLE || eol) ? '0 : col_q + 1'b1;
    if (state_d == ST_IDLE) col_d = '0;

    line_d = line_q;
    if (state_d != state_q) line_d = '0;
    else if (eol)           line_d = line_q + 1'b1;

    y_d = y_q;
    if (state_d != ST_ACTIVE)                y_d = '0;
    else if (state_q == ST_ACTIVE && eol)    y_d = y_q + 1'b1;

    bcnt_d = bcnt_q;
    bar_d  = bar_q;
    if (col_d == '0) begin
      bcnt_d = '0;
      bar_d  = '0;
    end else if (!col_d[0]) begin
      if (bcnt_q == BAR_LAST) begin
        bcnt_d = '0;
        bar_d  = bar_q + 3'd1;
      end else begin
        bcnt_d = bcnt_q + 1'b1;
      end
    end

    mode_d  = mode_q;
    solid_d = solid_q;
    if (state_d == ST_VSYNC && state_q != ST_VSYNC) begin
      mode_d  = mode;
      solid_d = solid_rgb;
    end
  end

  // Counter and latched-config registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q   <= '0;
      line_q  <= '0;
      y_q     <= '0;
      bcnt_q  <= '0;
      bar_q   <= '0;
      mode_q  <= MODE_BARS;
      solid_q <= 12'h000;
    end else begin
      col_q   <= col_d;
      line_q  <= line_d;
      y_q     <= y_d;
      bcnt_q  <= bcnt_d;
      bar_q   <= bar_d;
      mode_q  <= mode_d;
      solid_q <= solid_d;
    end
  end

  assign x_full    = XY_W'(col_d >> 1);
  assign y_full    = XY_W'(y_d);
  assign unused_xy = ^{x_full[XY_W-1:6], y_full[XY_W-1:5]};

  ov7670_pattern_lut u_lut (
    .mode_i    (mode_d),
    .x_i       (x_full[5:0]),
    .y_i       (y_full[4:0]),
    .bar_idx_i (bar_d),
    .solid_i   (solid_d),
    .rgb_o     (rgb)
  );

  // Output next values from next-state counters
  always_comb begin
    vsync_d = (state_d == ST_VSYNC);
    href_d  = (state_d == ST_ACTIVE) && ({1'b0, col_d} < ACT_COLS);
    data_d  = 8'h00;
    if (href_d)
      data_d = col_d[0] ? rgb[7:0] : {4'h0, rgb[11:8]};
    fd_d = (state_d == ST_VFP) && (col_d == COL_LAST) &&
           (line_d == FP_LAST);
    fc_d = fc_q + {15'd0, fd_d};
  end

  // Output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      data_q  <= 8'h00;
      fd_q    <= 1'b0;
      fc_q    <= 16'd0;
    end else begin
      vsync_q <= vsync_d;
      href_q  <= href_d;
      data_q  <= data_d;
      fd_q    <= fd_d;
      fc_q    <= fc_d;
    end
  end

  assign vsync       = vsync_q;
  assign href        = href_q;
  assign data        = data_q;
  assign frame_done  = fd_q;
  assign frame_count = fc_q;

endmodule
